fle_k_cfg: RTL and testbench
============================

# fle_k_cfg

Parametrised fracturable logic element for the CLB fabric. It provides a K-input LUT that splits into two (K-1)-input LUTs, one flip-flop with a register-chain input and a scan path, and a self-tracking configuration chain. It is the generalised successor to the fixed 4-input fle: LUT width is a parameter, and a configuration state machine gates the outputs until a complete bitstream has been shifted in. One instance sits per FLE slot inside a clb; ccff chains daisy-chain between slots.

## Interface
- K, default 4: LUT input count, legal range 3..6.
- CFG_LEN, default 2**K+3: configuration chain length. Derived; must not be overridden.
- clk, input, 1: the single clock for configuration shift and user logic.
- rst_n, input, 1: asynchronous active-low reset.
- Test_en, input, 1: scan enable.
- fle_in, input, K: LUT inputs. fle_in[0] is the LSB of the LUT index.
- fle_regin, input, 1: register-chain input from the previous FLE.
- fle_sc_in, input, 1: scan-chain input.
- ccff_en, input, 1: configuration shift enable.
- ccff_head, input, 1: configuration serial input.
- fle_out, output, 2: logic outputs.
- fle_regout, output, 1: flip-flop Q, feeds the next FLE's regin.
- fle_sc_out, output, 1: scan-chain output.
- ccff_tail, output, 1: configuration serial output, cfg[CFG_LEN-1].
- cfg_done, output, 1: a complete configuration is loaded.
- cfg_err, output, 1: the last shift burst was incomplete.

## Operation
- **Configuration shift.** When ccff_en=1, each clk does cfg <= {cfg[CFG_LEN-2:0], ccff_head}. The first bit shifted in ends at cfg[CFG_LEN-1].
- **Configuration field map:**
  - cfg[2**K-1:0]: LUT mask.
  - cfg[2**K]: frac.
  - cfg[2**K+1]: ff_dsel. 0 = LUT, 1 = fle_regin.
  - cfg[2**K+2]: out0_reg. 1 = fle_out[0] comes from the flip-flop.
- **LUT decode:**
  - lut_full = mask[fle_in].
  - lut_a = mask[{1'b0, fle_in[K-2:0]}].
  - lut_b = mask[{1'b1, fle_in[K-2:0]}].
  - primary = frac ? lut_a : lut_full.
- **Outputs.** fle_out[0] = out0_reg ? ff_q : primary. fle_out[1] = frac ? lut_b : lut_full. Both are combinational from fle_in and the config bits.
- **Flip-flop.** D = Test_en ? fle_sc_in : (ff_dsel ? fle_regin : primary). It captures when state==DONE or Test_en=1 and otherwise holds. fle_regout = ff_q.
- **Gating.** While state!=DONE, fle_out = 2'b00. fle_regout and ccff_tail are never gated.
- **State machine.** A counter cnt saturates at CFG_LEN and has width clog2(CFG_LEN+1).
  - IDLE: ccff_en=1 → SHIFT, cnt=1.
  - SHIFT, ccff_en=1: cnt increments, saturating. Extra bits beyond CFG_LEN keep shifting out through ccff_tail.
  - SHIFT, ccff_en=0 with cnt==CFG_LEN: → DONE.
  - SHIFT, ccff_en=0 with cnt<CFG_LEN: → IDLE and cfg_err=1.
  - DONE, ccff_en=1: → SHIFT, cnt=1, cfg_done drops the same edge. Reconfiguration is allowed.
  - cfg_err clears on the next entry into SHIFT.
- **Outputs per state.** cfg_done=1 only in DONE.

## Timing
- **Reset values.** rst_n=0 asynchronously clears cfg, cnt, ff_q, cfg_err and cfg_done, and sets state=IDLE. Resulting outputs: fle_out=00, fle_regout=0, fle_sc_out=0, ccff_tail=0, cfg_done=0, cfg_err=0.
- **Reset release.** Release is synchronous to clk, with no extra cycles.
- **Reset mid-shift.** The partial configuration is lost and the block returns to IDLE with no error flagged.
- **Config-chain latency.** ccff_tail reflects ccff_head CFG_LEN enabled edges later.
- **cfg_done latency.** cfg_done rises on the first edge where ccff_en=0 after CFG_LEN enabled edges.
- **LUT path.** Zero-cycle combinational.
- **Register path.** fle_regin to fle_regout is 1 cycle, as is fle_sc_in to fle_sc_out.
- **Scan during configuration.** Test_en=1 during SHIFT clocks the flip-flop. fle_out remains gated.

## Configuration
- **FLE_SCAN_EN defined:** the Test_en scan mux is present and fle_sc_out = ff_q.
- **FLE_SCAN_EN undefined:** the scan mux is removed.
  - Test_en and fle_sc_in are ignored.
  - fle_sc_out is tied 0.
  - The flip-flop captures only when state==DONE.
  - Ports remain in both builds.

## Test plan
- **Reset.** With K=4, assert rst_n=0 mid-shift → all outputs 0, state IDLE. Release, shift 19 bits → cfg_done=1 one edge after ccff_en falls.
- **Non-fractured LUT.** Load mask=16'h8000, frac=0, ff_dsel=0, out0_reg=0. Drive fle_in=4'hF → fle_out=2'b11. Drive fle_in=4'hE → fle_out=2'b00.
- **Fractured LUT.** Load mask=16'h00FF, frac=1. Drive fle_in=4'h3 → fle_out[0]=1 (lut_a), fle_out[1]=0 (lut_b).
- **Register chain.** Load ff_dsel=1, out0_reg=1. Toggle fle_regin 0→1 → fle_regout=1 and fle_out[0]=1 exactly one clk later.
- **Incomplete burst.** Drop ccff_en after 10 bits → cfg_err=1, cfg_done=0, fle_out=00. A full 19-bit reload clears cfg_err and sets cfg_done.
- **Scan and pass-through.** With FLE_SCAN_EN defined, Test_en=1 and fle_sc_in pattern 1,0,1 → fle_sc_out shows the same pattern delayed 1 cycle. Shift 38 bits → ccff_tail reproduces the first 19 input bits.

Source files
------------

// File: rtl/fle_k_cfg_if.sv
// fle_k_cfg_if: user-logic, scan and configuration-chain signals of one FLE slot.
// master drives the FLE inputs; slave is the FLE itself.
interface fle_k_cfg_if #(
    parameter int K = 4
);
    logic         Test_en;
    logic [K-1:0] fle_in;
    logic         fle_regin;
    logic         fle_sc_in;
    logic         ccff_en;
    logic         ccff_head;
    logic [1:0]   fle_out;
    logic         fle_regout;
    logic         fle_sc_out;
    logic         ccff_tail;
    logic         cfg_done;
    logic         cfg_err;

    modport master (
        output Test_en,
        output fle_in,
        output fle_regin,
        output fle_sc_in,
        output ccff_en,
        output ccff_head,
        input  fle_out,
        input  fle_regout,
        input  fle_sc_out,
        input  ccff_tail,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  Test_en,
        input  fle_in,
        input  fle_regin,
        input  fle_sc_in,
        input  ccff_en,
        input  ccff_head,
        output fle_out,
        output fle_regout,
        output fle_sc_out,
        output ccff_tail,
        output cfg_done,
        output cfg_err
    );
endinterface

// File: rtl/fle_k_cfg.sv
// fle_k_cfg: fracturable K-input LUT, one flip-flop and a self-tracking config chain.
// Optional scan mux enabled by defining FLE_SCAN_EN.
module fle_k_cfg #(
    parameter  int K       = 4,
    localparam int M       = 2**K,
    localparam int CFG_LEN = M + 3,
    localparam int CW      = $clog2(CFG_LEN + 1)
) (
    input logic        clk,
    input logic        rst_n,
    fle_k_cfg_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [CFG_LEN-1:0] r_cfg;
    logic               r_ff_q;

    logic [M-1:0]       w_mask;
    logic               w_frac;
    logic               w_dsel;
    logic               w_o0reg;
    logic [K-2:0]       w_lo;
    logic               w_full;
    logic               w_lut_a;
    logic               w_lut_b;
    logic               w_prim;
    logic               w_out1;
    logic               w_out0;
    logic               w_done;
    logic               w_ff_en;
    logic               w_ff_d;
    logic               w_ff_func;

    assign w_mask  = r_cfg[M-1:0];
    assign w_frac  = r_cfg[M];
    assign w_dsel  = r_cfg[M+1];
    assign w_o0reg = r_cfg[M+2];
    assign w_done  = (r_state == S_DONE);

    assign w_lo    = bus.fle_in[K-2:0];
    assign w_full  = w_mask[bus.fle_in];
    assign w_lut_a = w_mask[{1'b0, w_lo}];
    assign w_lut_b = w_mask[{1'b1, w_lo}];
    assign w_prim  = w_frac ? w_lut_a : w_full;
    assign w_out1  = w_frac ? w_lut_b : w_full;
    assign w_out0  = w_o0reg ? r_ff_q : w_prim;

    assign w_ff_func = w_dsel ? bus.fle_regin : w_prim;

`ifdef FLE_SCAN_EN
    assign w_ff_en        = w_done | bus.Test_en;
    assign w_ff_d         = bus.Test_en ? bus.fle_sc_in : w_ff_func;
    assign bus.fle_sc_out = r_ff_q;
`else
    logic w_unused;
    assign w_unused       = bus.Test_en ^ bus.fle_sc_in;
    assign w_ff_en        = w_done;
    assign w_ff_d         = w_ff_func;
    assign bus.fle_sc_out = 1'b0;
`endif

    // Outputs stay quiet until a complete bitstream is loaded.
    assign bus.fle_out    = w_done ? {w_out1, w_out0} : 2'b00;
    assign bus.fle_regout = r_ff_q;
    assign bus.ccff_tail  = r_cfg[CFG_LEN-1];
    assign bus.cfg_done   = w_done;
    assign bus.cfg_err    = r_err;

    // Next-state: count burst length, decide done vs error when enable drops.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.ccff_en) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = CW'(1);
                    w_err_nxt   = 1'b0;
                end
            end
            S_SHIFT: begin
                if (bus.ccff_en) begin
                    if (r_cnt != CW'(CFG_LEN)) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else if (r_cnt == CW'(CFG_LEN)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, burst counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Configuration shift register; first bit in ends at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else if (bus.ccff_en) begin
            r_cfg <= {r_cfg[CFG_LEN-2:0], bus.ccff_head};
        end
    end

    // User flip-flop: captures in DONE, or whenever scan is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_q <= 1'b0;
        end else if (w_ff_en) begin
            r_ff_q <= w_ff_d;
        end
    end

endmodule

// File: tb/tb_fle_k_cfg.sv
// tb_fle_k_cfg: randomized self-checking bench for fle_k_cfg (K=4)
// against a bit-queue behavioural model.
module tb_fle_k_cfg;
    localparam int K = 4;
    localparam int M = 2**K;
    localparam int L = M + 3;
    localparam int H = M / 2;
`ifdef FLE_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fle_k_cfg_if #(.K(K)) bus ();

    fle_k_cfg #(.K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit q[$];
    bit m_run;
    int m_burst;
    bit m_done;
    bit m_err;
    bit m_ff;

    task automatic m_reset();
        q.delete();
        m_run   = 1'b0;
        m_burst = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_ff    = 1'b0;
    endtask

    function automatic logic [L-1:0] m_cfg();
        logic [L-1:0] c;
        c = '0;
        for (int i = 0; i < L; i++)
            if (i < q.size()) c[i] = q[q.size()-1-i];
        return c;
    endfunction

    // {out1, primary}
    function automatic logic [1:0] m_lut(input int idx);
        logic [L-1:0] c;
        int lo;
        logic full, a, b, fr;
        c    = m_cfg();
        lo   = idx % H;
        full = c[idx];
        a    = c[lo];
        b    = c[lo + H];
        fr   = c[M];
        return {fr ? b : full, fr ? a : full};
    endfunction

    function automatic logic [6:0] m_exp();
        logic [L-1:0] c;
        logic [1:0] l;
        logic [1:0] o;
        c = m_cfg();
        l = m_lut(int'(bus.fle_in));
        o = m_done ? {l[1], c[M+2] ? m_ff : l[0]} : 2'b00;
        return {o, m_ff, SCAN & m_ff, c[L-1], m_done, m_err};
    endfunction

    function automatic logic [6:0] act();
        return {bus.fle_out, bus.fle_regout, bus.fle_sc_out,
                bus.ccff_tail, bus.cfg_done, bus.cfg_err};
    endfunction

    task automatic m_edge();
        logic [L-1:0] c;
        logic [1:0] l;
        bit scan;
        if (!rst_n) begin
            m_reset();
            return;
        end
        c    = m_cfg();
        l    = m_lut(int'(bus.fle_in));
        scan = SCAN && bus.Test_en;
        if (m_done || scan)
            m_ff = scan ? bus.fle_sc_in : (c[M+1] ? bus.fle_regin : l[0]);
        if (bus.ccff_en) begin
            q.push_back(bus.ccff_head);
            if (q.size() > L) void'(q.pop_front());
            if (!m_run) begin
                m_run   = 1'b1;
                m_burst = 0;
                m_err   = 1'b0;
                m_done  = 1'b0;
            end
            m_burst++;
        end else if (m_run) begin
            m_run = 1'b0;
            if (m_burst >= L) m_done = 1'b1;
            else m_err = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic load_cfg(input logic [M-1:0] mask, input bit fr,
                            input bit dsel, input bit o0r);
        logic [L-1:0] v;
        v = {o0r, dsel, fr, mask};
        for (int i = L - 1; i >= 0; i--) begin
            bus.ccff_en   = 1'b1;
            bus.ccff_head = v[i];
            tick();
        end
        bus.ccff_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [6:0] a;
        bus.Test_en = 0; bus.fle_in = '0; bus.fle_regin = 0;
        bus.fle_sc_in = 0; bus.ccff_en = 0; bus.ccff_head = 0;
        rst_n = 1'b0;
        m_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        a = act();
        n_cmp++;
        if (a !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_init: got %b want %b", a, 7'b0);
        end
        for (int i = 0; i < 7; i++) begin
            bus.ccff_en   = 1'b1;
            bus.ccff_head = 1'($urandom);
            tick();
        end
        rst_n = 1'b0;
        #1;
        a = act();
        n_cmp++;
        if (a !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_midshift: got %b want %b", a, 7'b0);
        end
        bus.ccff_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        a = act();
        n_cmp++;
        if (a !== m_exp() || a !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", a, 7'b0);
        end
        for (int i = 0; i < L; i++) begin
            bus.ccff_en   = 1'b1;
            bus.ccff_head = 1'($urandom);
            tick();
        end
        n_cmp++;
        if (bus.cfg_done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_early: got %b want 0", bus.cfg_done);
        end
        bus.ccff_en = 1'b0;
        tick();
        n_cmp++;
        if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL done_latency: got done=%b err=%b want 1 0",
                     bus.cfg_done, bus.cfg_err);
        end
    endtask

    task automatic test_nonfrac();
        load_cfg(16'h8000, 1'b0, 1'b0, 1'b0);
        bus.fle_in = 4'hF;
        #1;
        n_cmp++;
        if (bus.fle_out !== 2'b11) begin
            n_bad++;
            $display("FAIL nonfrac_F: got %b want 11", bus.fle_out);
        end
        bus.fle_in = 4'hE;
        #1;
        n_cmp++;
        if (bus.fle_out !== 2'b00) begin
            n_bad++;
            $display("FAIL nonfrac_E: got %b want 00", bus.fle_out);
        end
        @(negedge clk);
    endtask

    task automatic test_frac();
        load_cfg(16'h00FF, 1'b1, 1'b0, 1'b0);
        bus.fle_in = 4'h3;
        #1;
        n_cmp++;
        if (bus.fle_out !== 2'b01) begin
            n_bad++;
            $display("FAIL frac_3: got %b want 01", bus.fle_out);
        end
        bus.fle_in = 4'hB;
        #1;
        n_cmp++;
        if (bus.fle_out !== 2'b01) begin
            n_bad++;
            $display("FAIL frac_B: got %b want 01", bus.fle_out);
        end
        @(negedge clk);
    endtask

    task automatic test_regchain();
        load_cfg(16'h0000, 1'b0, 1'b1, 1'b1);
        bus.fle_regin = 1'b0;
        tick();
        bus.fle_regin = 1'b1;
        #1;
        n_cmp++;
        if (bus.fle_regout !== 1'b0) begin
            n_bad++;
            $display("FAIL regchain_hold: got %b want 0", bus.fle_regout);
        end
        @(negedge clk);
        tick();
        n_cmp++;
        if (bus.fle_regout !== 1'b1 || bus.fle_out[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL regchain_1cyc: got regout=%b out0=%b want 1 1",
                     bus.fle_regout, bus.fle_out[0]);
        end
        bus.fle_regin = 1'b0;
    endtask

    task automatic test_incomplete();
        for (int i = 0; i < 10; i++) begin
            bus.ccff_en   = 1'b1;
            bus.ccff_head = 1'($urandom);
            tick();
        end
        bus.ccff_en = 1'b0;
        bus.fle_in  = 4'($urandom);
        tick();
        n_cmp++;
        if ({bus.cfg_err, bus.cfg_done, bus.fle_out} !== 4'b1000) begin
            n_bad++;
            $display("FAIL incomplete: got err=%b done=%b out=%b want 1 0 00",
                     bus.cfg_err, bus.cfg_done, bus.fle_out);
        end
        load_cfg(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        n_cmp++;
        if (bus.cfg_err !== 1'b0 || bus.cfg_done !== 1'b1) begin
            n_bad++;
            $display("FAIL reload: got err=%b done=%b want 0 1",
                     bus.cfg_err, bus.cfg_done);
        end
    endtask

    task automatic test_scan();
        bit pat[3] = '{1'b1, 1'b0, 1'b1};
        bus.Test_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fle_sc_in = pat[i];
            tick();
            n_cmp++;
            if (bus.fle_sc_out !== (SCAN & pat[i]) || act() !== m_exp()) begin
                n_bad++;
                $display("FAIL scan_%0d: got sc=%b all=%b want sc=%b all=%b",
                         i, bus.fle_sc_out, act(), SCAN & pat[i], m_exp());
            end
        end
        bus.Test_en   = 1'b0;
        bus.fle_sc_in = 1'b0;
    endtask

    task automatic test_passthrough();
        bit bits[2*L];
        foreach (bits[j]) bits[j] = 1'($urandom);
        for (int j = 0; j < 2 * L; j++) begin
            bus.ccff_en   = 1'b1;
            bus.ccff_head = bits[j];
            tick();
            if (j >= L - 1) begin
                n_cmp++;
                if (bus.ccff_tail !== bits[j+1-L]) begin
                    n_bad++;
                    $display("FAIL tail_%0d: got %b want %b",
                             j, bus.ccff_tail, bits[j+1-L]);
                end
            end
        end
        bus.ccff_en = 1'b0;
        tick();
        n_cmp++;
        if (bus.cfg_done !== 1'b1) begin
            n_bad++;
            $display("FAIL long_burst_done: got %b want 1", bus.cfg_done);
        end
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic [6:0] e;
        for (int b = 0; b < 12; b++) begin
            int len;
            int gap;
            len = (b % 3 == 0) ? L : int'($urandom_range(4, 26));
            gap = int'($urandom_range(1, 10));
            for (int i = 0; i < len + gap; i++) begin
                bus.ccff_en   = (i < len);
                bus.ccff_head = 1'($urandom);
                bus.fle_in    = 4'($urandom);
                bus.fle_regin = 1'($urandom);
                bus.Test_en   = ($urandom_range(0, 7) == 0);
                bus.fle_sc_in = 1'($urandom);
                tick();
                a = act();
                e = m_exp();
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL random_b%0d_c%0d: got %b want %b", b, i, a, e);
                end
            end
        end
        bus.Test_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nonfrac();
        test_frac();
        test_regchain();
        test_incomplete();
        test_scan();
        test_passthrough();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
